vjtag_tap_ctrl: RTL and testbench
=================================

// Module: vjtag_tap_ctrl
// PURPOSE
//  IEEE 1149.1-style TAP state machine driven by tms/tdi on tck.
//  Generates the instruction register ir_in and the capture/shift/update strobes
//  (v_cdr, v_sdr, v_udr, v_cir, v_sir, v_uir) that sequence the LED/DIP DR datapath.
//  Muxes tdo between the IR shift register and the datapath's dr_tdo.
// PARAMETERS
//  IR_W     2     instruction register width (>=2)
//  IR_RST   0     ir_in value in TEST_LOGIC_RESET and after reset (BYPASS)
// PORTS
//  tck       in   1     clock; all state changes on posedge
//  aclr      in   1     reset, synchronous, active-high
//  tms       in   1     TAP mode select, sampled on posedge tck
//  tdi       in   1     serial data in; shifted into IR in SHIFT_IR
//  dr_tdo    in   1     serial out of selected DR (from datapath)
//  ir_in     out  IR_W  current instruction, to datapath
//  v_cdr     out  1     high while state==CAPTURE_DR
//  v_sdr     out  1     high while state==SHIFT_DR
//  v_udr     out  1     high while state==UPDATE_DR
//  v_cir     out  1     high while state==CAPTURE_IR
//  v_sir     out  1     high while state==SHIFT_IR
//  v_uir     out  1     high while state==UPDATE_IR
//  tdo       out  1     ir_sr[0] while SHIFT_IR, else dr_tdo
//  tap_state out  4     current state encoding (debug)
// BEHAVIOUR
//  - Reset (aclr=1 at posedge): state<=TLR, ir_in<=IR_RST, ir_sr<=0.
//    Strobes are decodes of state, so all six are 0 in the cycle after reset.
//  - Encoding: TLR=0 RTI=1 SEL_DR=2 CAP_DR=3 SH_DR=4 EX1_DR=5 PAU_DR=6 EX2_DR=7
//    UPD_DR=8 SEL_IR=9 CAP_IR=10 SH_IR=11 EX1_IR=12 PAU_IR=13 EX2_IR=14 UPD_IR=15.
//  - Transitions, next state for tms=0 / tms=1:
//    TLR:RTI/TLR  RTI:RTI/SEL_DR  SEL_DR:CAP_DR/SEL_IR  SEL_IR:CAP_IR/TLR
//    CAP_x:SH_x/EX1_x  SH_x:SH_x/EX1_x  EX1_x:PAU_x/UPD_x  PAU_x:PAU_x/EX2_x
//    EX2_x:SH_x/UPD_x  UPD_x:RTI/SEL_DR   (x = DR or IR)
//  - Five consecutive tms=1 cycles reach TLR from any state.
//  - Strobes are combinational decodes of the registered state: exactly one cycle
//    per visit to CAP/UPD; v_sdr/v_sir stay high for every cycle spent in SH_x.
//    At most one strobe is high in any cycle.
//  - IR path, on posedge with current state:
//    CAP_IR: ir_sr <= {{IR_W-2}0, 2'b01}
//    SH_IR:  ir_sr <= {tdi, ir_sr[IR_W-1:1]}   (LSB first)
//    UPD_IR: ir_in <= ir_sr
//    TLR:    ir_in <= IR_RST
//    ir_in holds its value in every other state, including through DR scans.
//  - tdo is combinational: ir_sr[0] in SH_IR, otherwise dr_tdo (incl. BYPASS).
//  - Pausing (PAU_x) or leaving via EX1/EX2 without UPD_x leaves ir_in unchanged.
//  - Reset mid-scan: aclr wins over tms; any partial ir_sr contents are discarded
//    and no update strobe is issued.
// TESTING
//  1 aclr=1 for 2 cycles -> tap_state=0, ir_in=0, all strobes 0, tdo=dr_tdo.
//  2 From SH_DR, tms=1 x5 -> states 5,8,2,9,0; ir_in returns to IR_RST.
//  3 From RTI, tms 1,1,0,0 then tdi=0,1 (tms=0,1), tms=1,0 -> v_uir pulses once;
//    ir_in=2'b10; tdo during SH_IR shows captured 1 then 0.
//  4 ir_in=2'b10; from RTI tms 1,0,0 then 8 cycles in SH_DR -> v_cdr 1 cycle,
//    v_sdr exactly 8 cycles, v_udr 1 cycle after EX1_DR; ir_in unchanged.
//  5 SH_IR -> EX1 -> PAU (3 cycles) -> EX2 -> SH_IR: v_sir low in pause,
//    ir_sr holds; after UPD_IR the shifted value is intact.
//  6 aclr=1 asserted in SH_IR after 1 bit -> TLR next cycle, no v_uir,
//    ir_in=IR_RST.

Source files
------------

// File: rtl/vjtag_tap_ctrl_if.sv
// ---------------------------------------------------------------------------
// vjtag_tap_ctrl_if : TAP serial pins, datapath strobes and debug state bus
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface vjtag_tap_ctrl_if #(
  parameter int IR_W = 2
) ();
  logic            tms;
  logic            tdi;
  logic            dr_tdo;
  logic [IR_W-1:0] ir_in;
  logic            v_cdr;
  logic            v_sdr;
  logic            v_udr;
  logic            v_cir;
  logic            v_sir;
  logic            v_uir;
  logic            tdo;
  logic [3:0]      tap_state;

  modport master (
    output tms, tdi, dr_tdo,
    input  ir_in, v_cdr, v_sdr, v_udr, v_cir, v_sir, v_uir, tdo, tap_state
  );

  modport slave (
    input  tms, tdi, dr_tdo,
    output ir_in, v_cdr, v_sdr, v_udr, v_cir, v_sir, v_uir, tdo, tap_state
  );
endinterface

`default_nettype wire

// File: rtl/vjtag_tap_ctrl.sv
// ---------------------------------------------------------------------------
// vjtag_tap_ctrl : 1149.1-style TAP FSM, instruction register and tdo mux
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vjtag_tap_ctrl #(
  parameter int              IR_W   = 2,
  parameter logic [IR_W-1:0] IR_RST = '0
) (
  input  logic             tck,
  input  logic             aclr,
  vjtag_tap_ctrl_if.slave  bus
);

  localparam logic [3:0] S_TLR    = 4'd0;
  localparam logic [3:0] S_RTI    = 4'd1;
  localparam logic [3:0] S_SEL_DR = 4'd2;
  localparam logic [3:0] S_CAP_DR = 4'd3;
  localparam logic [3:0] S_SH_DR  = 4'd4;
  localparam logic [3:0] S_EX1_DR = 4'd5;
  localparam logic [3:0] S_PAU_DR = 4'd6;
  localparam logic [3:0] S_EX2_DR = 4'd7;
  localparam logic [3:0] S_UPD_DR = 4'd8;
  localparam logic [3:0] S_SEL_IR = 4'd9;
  localparam logic [3:0] S_CAP_IR = 4'd10;
  localparam logic [3:0] S_SH_IR  = 4'd11;
  localparam logic [3:0] S_EX1_IR = 4'd12;
  localparam logic [3:0] S_PAU_IR = 4'd13;
  localparam logic [3:0] S_EX2_IR = 4'd14;
  localparam logic [3:0] S_UPD_IR = 4'd15;

  logic [3:0]      state_q, state_d;
  logic [IR_W-1:0] ir_sr_q, ir_sr_d;
  logic [IR_W-1:0] ir_in_q, ir_in_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_TLR:    state_d = bus.tms ? S_TLR    : S_RTI;
      S_RTI:    state_d = bus.tms ? S_SEL_DR : S_RTI;
      S_SEL_DR: state_d = bus.tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: state_d = bus.tms ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  state_d = bus.tms ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: state_d = bus.tms ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: state_d = bus.tms ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: state_d = bus.tms ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: state_d = bus.tms ? S_SEL_DR : S_RTI;
      S_SEL_IR: state_d = bus.tms ? S_TLR    : S_CAP_IR;
      S_CAP_IR: state_d = bus.tms ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  state_d = bus.tms ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: state_d = bus.tms ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: state_d = bus.tms ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: state_d = bus.tms ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: state_d = bus.tms ? S_SEL_DR : S_RTI;
      default:  state_d = S_TLR;
    endcase
  end

  // Capture loads the fixed 0..01 pattern; shifting is LSB-first from tdi.
  always_comb begin
    ir_sr_d = ir_sr_q;
    ir_in_d = ir_in_q;
    case (state_q)
      S_CAP_IR: begin
        ir_sr_d    = '0;
        ir_sr_d[0] = 1'b1;
      end
      S_SH_IR:  ir_sr_d = {bus.tdi, ir_sr_q[IR_W-1:1]};
      S_UPD_IR: ir_in_d = ir_sr_q;
      S_TLR:    ir_in_d = IR_RST;
      default:  ;
    endcase
  end

  always_ff @(posedge tck) begin
    if (aclr) begin
      state_q <= S_TLR;
      ir_sr_q <= '0;
      ir_in_q <= IR_RST;
    end else begin
      state_q <= state_d;
      ir_sr_q <= ir_sr_d;
      ir_in_q <= ir_in_d;
    end
  end

  assign bus.v_cdr     = (state_q == S_CAP_DR);
  assign bus.v_sdr     = (state_q == S_SH_DR);
  assign bus.v_udr     = (state_q == S_UPD_DR);
  assign bus.v_cir     = (state_q == S_CAP_IR);
  assign bus.v_sir     = (state_q == S_SH_IR);
  assign bus.v_uir     = (state_q == S_UPD_IR);
  assign bus.tdo       = (state_q == S_SH_IR) ? ir_sr_q[0] : bus.dr_tdo;
  assign bus.ir_in     = ir_in_q;
  assign bus.tap_state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_vjtag_tap_ctrl.sv
// Testbench for vjtag_tap_ctrl: directed TAP scans plus random tms/tdi traffic
// compared cycle by cycle against a behavioural TAP model.
`default_nettype none

module tb_vjtag_tap_ctrl;
  localparam int IR_W = 2;
  localparam int IR_RST_VAL = 0;

  logic tck = 1'b0;
  logic aclr;

  vjtag_tap_ctrl_if #(.IR_W(IR_W)) bus ();

  vjtag_tap_ctrl #(.IR_W(IR_W), .IR_RST(IR_RST_VAL[IR_W-1:0])) dut (
    .tck  (tck),
    .aclr (aclr),
    .bus  (bus)
  );

  always #5 tck = ~tck;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Behavioural model: state names by number, IR kept as plain integers.
  int m_state, m_ir_in, m_ir_sr;
  bit m_valid = 0;
  int cnt_cdr, cnt_sdr, cnt_udr, cnt_sir, cnt_uir;

  function automatic int tap_next(input int s, input bit t);
    case (s)
      0:  return t ? 0 : 1;
      1:  return t ? 2 : 1;
      2:  return t ? 9 : 3;
      9:  return t ? 0 : 10;
      3, 10:  return t ? s + 2 : s + 1;   // capture -> exit1 / shift
      4, 11:  return t ? s + 1 : s;       // shift   -> exit1 / shift
      5, 12:  return t ? s + 3 : s + 1;   // exit1   -> update / pause
      6, 13:  return t ? s + 1 : s;       // pause   -> exit2 / pause
      7, 14:  return t ? s + 1 : s - 3;   // exit2   -> update / shift
      default: return t ? 2 : 1;          // update  -> sel_dr / rti
    endcase
  endfunction

  task automatic step(input bit a, input bit m, input bit d);
    logic [5:0] exp_strb;
    logic [5:0] obs_strb;
    int mask;
    mask = (1 << IR_W) - 1;
    aclr = a;
    bus.tms = m;
    bus.tdi = d;
    bus.dr_tdo = 1'($urandom_range(0, 1));
    #1;
    if (m_valid) begin
      exp_strb = {m_state == 3, m_state == 4, m_state == 8,
                  m_state == 10, m_state == 11, m_state == 15};
      obs_strb = {bus.v_cdr, bus.v_sdr, bus.v_udr, bus.v_cir, bus.v_sir, bus.v_uir};
      check_val("tap_state", 32'(bus.tap_state), 32'(m_state));
      check_val("ir_in", 32'(bus.ir_in), 32'(m_ir_in));
      check_val("strobes", 32'(obs_strb), 32'(exp_strb));
      check_val("tdo", 32'(bus.tdo),
                32'((m_state == 11) ? (m_ir_sr & 1) : int'(bus.dr_tdo)));
      cnt_cdr += int'(bus.v_cdr);
      cnt_sdr += int'(bus.v_sdr);
      cnt_udr += int'(bus.v_udr);
      cnt_sir += int'(bus.v_sir);
      cnt_uir += int'(bus.v_uir);
    end
    @(posedge tck);
    if (a) begin
      m_state = 0; m_ir_in = IR_RST_VAL; m_ir_sr = 0; m_valid = 1;
    end else begin
      if (m_state == 10) m_ir_sr = 1;
      else if (m_state == 11) m_ir_sr = ((m_ir_sr >> 1) | (int'(d) << (IR_W - 1))) & mask;
      else if (m_state == 15) m_ir_in = m_ir_sr;
      else if (m_state == 0) m_ir_in = IR_RST_VAL;
      m_state = tap_next(m_state, m);
    end
    @(negedge tck);
  endtask

  task automatic clr_cnt();
    cnt_cdr = 0; cnt_sdr = 0; cnt_udr = 0; cnt_sir = 0; cnt_uir = 0;
  endtask

  initial begin
    aclr = 1'b1; bus.tms = 1'b1; bus.tdi = 1'b0; bus.dr_tdo = 1'b0;
    clr_cnt();
    @(negedge tck);

    // Reset held for two cycles
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);                                  // TLR -> RTI, checks reset state

    // IR scan loading 2'b10; tdo shows captured 1 then 0
    clr_cnt();
    step(0, 1, 0); step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    step(0, 0, 0); step(0, 1, 1); step(0, 1, 0); step(0, 0, 0);
    check_val("t3_ir_in", 32'(bus.ir_in), 32'h2);
    check_val("t3_uir_cnt", 32'(cnt_uir), 32'd1);

    // DR scan of 8 shift cycles; ir_in must not move
    clr_cnt();
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1'($urandom_range(0, 1)));
    step(0, 1, 0); step(0, 1, 0); step(0, 0, 0);
    check_val("t4_cdr_cnt", 32'(cnt_cdr), 32'd1);
    check_val("t4_sdr_cnt", 32'(cnt_sdr), 32'd8);
    check_val("t4_udr_cnt", 32'(cnt_udr), 32'd1);
    check_val("t4_ir_in", 32'(bus.ir_in), 32'h2);

    // SH_DR then tms=1 x5 reaches TLR, ir_in back to reset value
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    check_val("t2_state", 32'(bus.tap_state), 32'd0);
    step(0, 0, 0);
    check_val("t2_ir_in", 32'(bus.ir_in), 32'(IR_RST_VAL));

    // IR scan with a 3-cycle pause; shifted value survives to update
    clr_cnt();
    step(0, 1, 0); step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    step(0, 0, 1); step(0, 1, 1);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 1, 0);
    step(0, 0, 0); step(0, 1, 0); step(0, 1, 0); step(0, 0, 0);
    check_val("t5_sir_cnt", 32'(cnt_sir), 32'd3);
    check_val("t5_ir_in", 32'(bus.ir_in), 32'h1);

    // Reset mid IR shift: no update strobe, ir_in back to reset value
    clr_cnt();
    step(0, 1, 0); step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    step(0, 0, 1);
    step(1, 0, 1);
    check_val("t6_state", 32'(bus.tap_state), 32'd0);
    check_val("t6_ir_in", 32'(bus.ir_in), 32'(IR_RST_VAL));
    check_val("t6_uir_cnt", 32'(cnt_uir), 32'd0);

    // Random traffic, occasionally forced back to TLR by five tms=1
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        for (int k = 0; k < 5; k++) step(0, 1, 0);
        check_val("rand_tlr", 32'(bus.tap_state), 32'd0);
      end else begin
        step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 40),
             1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
